imm_encoder: RTL and testbench

- Streaming immediate encoder: the inverse of the core's immediate generator.
- Accepts a base instruction word, a 32-bit immediate and a format selector. Range-checks the immediate, packs it into the format's instruction bit-fields and emits the finished word with a running word address.
- Sits between the test-program loader/assembler front end and the instruction-memory write port. Valid/ready on both sides, one pipeline register.

---
 rtl/imm_encoder.sv | 197 +++++++++++++++++++
 tb/tb_imm_encoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder
//   Streaming immediate encoder, the inverse of the core's immediate generator.
//   A request carries a base instruction word, a 32-bit two's-complement
//   immediate and a format selector (00 I, 01 S, 10 B, 11 U). The immediate
//   is range-checked and packed into the format's instruction bit-fields.
//   The finished word is emitted through a single output register, together
//   with a running byte address. Valid/ready handshakes are used on both sides.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   clr         synchronous clear of the address counter and the error counter
//   in_valid    request valid
//   in_ready    request accepted when in_valid && in_ready
//   in_base     base instruction; bits outside the immediate fields pass through
//   in_imm      immediate value, two's complement
//   in_imm_sel  format selector
//   out_valid   encoded word valid
//   out_ready   sink accepts when out_valid && out_ready
//   out_instr   encoded instruction
//   out_addr    byte address of out_instr
//   out_err     immediate was out of range or misaligned for its format
//   err_count   saturating count of errored words
//
// Parameters
//   ADDR_W      width of the address counter (wraps modulo 2^ADDR_W)
//   ADDR_BASE   address loaded at reset and on clr; must be 4-byte aligned
//
// Build option
//   IMM_ENCODER_STRICT_EN : errored requests are still accepted, but they are
//   dropped. They never reach the output and do not advance out_addr.
//   err_count counts them when they are accepted, and out_err is tied to 0.

module imm_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] ADDR_BASE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_base,
  input  logic [31:0]       in_imm,
  input  logic [1:0]        in_imm_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {
    FMT_I = 2'b00,
    FMT_S = 2'b01,
    FMT_B = 2'b10,
    FMT_U = 2'b11
  } fmt_e;

  fmt_e fmt;
  assign fmt = fmt_e'(in_imm_sel);

  // ---------------------------------------------------------------------------
  // Field packing and range check (combinational, on the incoming request)
  // ---------------------------------------------------------------------------
  // fits12: the immediate is representable as a sign-extended 12-bit value,
  // i.e. the bits from the sign position up to bit 31 are all equal.
  // fits13: the same check for a 13-bit value, used by B.
  logic fits12;
  logic fits13;
  logic low12_zero;

  assign fits12     = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits13     = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign low12_zero = ~(|in_imm[11:0]);

  logic [31:0] enc_instr;
  logic        enc_err;

  always_comb begin
    enc_instr = in_base;
    enc_err   = 1'b0;
    unique case (fmt)
      FMT_I: begin
        enc_instr[31:20] = in_imm[11:0];
        enc_err          = ~fits12;
      end
      FMT_S: begin
        enc_instr[31:25] = in_imm[11:5];
        enc_instr[11:7]  = in_imm[4:0];
        enc_err          = ~fits12;
      end
      FMT_B: begin
        enc_instr[31]    = in_imm[12];
        enc_instr[30:25] = in_imm[10:5];
        enc_instr[11:8]  = in_imm[4:1];
        enc_instr[7]     = in_imm[11];
        enc_err          = ~fits13 | in_imm[0];
      end
      FMT_U: begin
        enc_instr[31:12] = in_imm[31:12];
        enc_err          = ~low12_zero;
      end
      default: begin
        enc_instr = in_base;
        enc_err   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register and counters
  // ---------------------------------------------------------------------------
  logic              valid_q,  valid_d;
  logic [31:0]       instr_q,  instr_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [7:0]        cnt_q,    cnt_d;

  logic accept;
  logic out_hs;
  logic load;
  logic cnt_inc;

  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign out_hs   = valid_q & out_ready;

`ifdef IMM_ENCODER_STRICT_EN
  // Errored requests are consumed at the input and never occupy the register.
  assign load    = accept & ~enc_err;
  assign cnt_inc = accept & enc_err;
  assign out_err = 1'b0;
`else
  logic err_q, err_d;

  assign load    = accept;
  assign cnt_inc = out_hs & err_q;
  assign out_err = err_q;

  always_comb begin
    err_d = err_q;
    if (load) err_d = enc_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`endif

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    // A load takes precedence over the drain. This replaces the word in the
    // same edge as its handshake, so no bubble is inserted.
    if (load) begin
      valid_d = 1'b1;
      instr_d = enc_instr;
    end else if (out_hs) begin
      valid_d = 1'b0;
    end
  end

  // clr overrides a simultaneous handshake, but it leaves the register alone.
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (clr) begin
      addr_d = ADDR_BASE;
      cnt_d  = '0;
    end else begin
      if (out_hs) addr_d = addr_q + ADDR_W'(4);
      if (cnt_inc && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      addr_q  <= ADDR_BASE;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_addr  = addr_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Testbench for imm_encoder (default build). The DUT uses a 4-bit address
// counter based at 12, so the address wraps frequently.
module tb_imm_encoder;

  localparam int unsigned ADDR_W = 4;
  localparam int          BASE   = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_base;
  logic [31:0]       in_imm;
  logic [1:0]        in_imm_sel;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic [7:0]        err_count;

  int tests  = 0;
  int failed = 0;

  imm_encoder #(.ADDR_W(ADDR_W), .ADDR_BASE(4'd12)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_base(in_base), .in_imm(in_imm), .in_imm_sel(in_imm_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: arithmetic range checks plus mask/shift packing
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  function automatic exp_t model_encode(input logic [31:0] base, input logic [31:0] imm,
                                        input logic [1:0] sel);
    exp_t r;
    int   s;
    s = int'(imm);
    case (sel)
      2'd0: begin
        r.instr = (base & 32'h000F_FFFF) | (imm << 20);
        r.err   = !(s >= -2048 && s <= 2047);
      end
      2'd1: begin
        r.instr = (base & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
        r.err   = !(s >= -2048 && s <= 2047);
      end
      2'd2: begin
        r.instr = (base & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31)
                | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                | (((imm >> 11) & 32'h1) << 7);
        r.err   = !(s >= -4096 && s <= 4095) || ((imm % 2) != 0);
      end
      default: begin
        r.instr = (base & 32'h0000_0FFF) | (imm & 32'hFFFF_F000);
        r.err   = (imm % 4096) != 0;
      end
    endcase
    return r;
  endfunction

  exp_t q[$];
  int   m_addr;
  int   m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_addr <= BASE;
      m_cnt  <= 0;
    end else begin
      bit occ, hs, acc;
      occ = (q.size() != 0);
      hs  = occ && out_ready;
      acc = in_valid && (!occ || out_ready);
      if (clr) begin
        m_addr <= BASE;
        m_cnt  <= 0;
      end else if (hs) begin
        m_addr <= (m_addr + 4) % 16;
        if (q[0].err && m_cnt < 255) m_cnt <= m_cnt + 1;
      end
      if (hs)  void'(q.pop_front());
      if (acc) q.push_back(model_encode(in_base, in_imm, in_imm_sel));
    end
  end

  // Compare process, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready",  32'(in_ready),  32'(q.size() == 0 || out_ready));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("out_addr",  32'(out_addr),  32'(m_addr));
      chk("err_count", 32'(err_count), 32'(m_cnt));
      if (q.size() != 0) begin
        chk("out_instr", out_instr,     q[0].instr);
        chk("out_err",   32'(out_err),  32'(q[0].err));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [31:0] b, input logic [31:0] i, input logic [1:0] s);
    in_valid   = 1'b1;
    in_base    = b;
    in_imm     = i;
    in_imm_sel = s;
  endtask

  function automatic logic [31:0] rand_imm();
    int bnd[12];
    int k;
    bnd = '{2047, -2048, 2048, -2049, 4094, -4096, 4095, 4096, -4098, 0, 1, -1};
    case ($urandom_range(0, 5))
      0: return $urandom;
      1: return 32'(int'($urandom_range(0, 4095)) - 2048);
      2: begin k = $urandom_range(0, 11); return 32'(bnd[k]); end
      3: return $urandom & 32'hFFFF_F000;
      4: return 32'(int'($urandom_range(0, 16383)) - 8192);
      default: return 32'($urandom_range(0, 4095)) << 12;
    endcase
  endfunction

  logic [31:0]       hold_instr;
  logic [ADDR_W-1:0] hold_addr;

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_base = '0; in_imm = '0; in_imm_sel = '0;
    #12 rst_n = 1'b1;
    tick;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err",   32'(out_err), 32'd0);
    chk("rst_out_addr",  32'(out_addr), 32'd12);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready",  32'(in_ready), 32'd1);

    // Directed vectors with hand-computed results
    out_ready = 1'b1;
    drive(32'h0000_0013, 32'hFFFF_FFFF, 2'b00); tick;
    chk("I_instr", out_instr, 32'hFFF0_0013);
    chk("I_err",   32'(out_err), 32'd0);
    chk("I_addr",  32'(out_addr), 32'd12);
    chk("I_valid", 32'(out_valid), 32'd1);
    drive(32'h0000_2023, 32'h0000_0008, 2'b01); tick;
    chk("S_instr", out_instr, 32'h0000_2423);
    chk("S_addr",  32'(out_addr), 32'd0);
    drive(32'h0000_0063, 32'hFFFF_FFFC, 2'b10); tick;
    chk("B_instr", out_instr, 32'hFE00_0EE3);
    chk("B_addr",  32'(out_addr), 32'd4);
    chk("B_valid", 32'(out_valid), 32'd1);
    drive(32'h0000_0037, 32'h1234_5000, 2'b11); tick;
    chk("U_instr", out_instr, 32'h1234_5037);
    chk("U_err",   32'(out_err), 32'd0);
    drive(32'h0000_0037, 32'h1234_5001, 2'b11); tick;
    chk("Uerr_instr", out_instr, 32'h1234_5037);
    chk("Uerr_err",   32'(out_err), 32'd1);
    chk("Uerr_cnt",   32'(err_count), 32'd0);
    drive(32'h0000_0013, 32'h0000_0800, 2'b00); tick;
    chk("Ierr_instr", out_instr, 32'h8000_0013);
    chk("Ierr_err",   32'(out_err), 32'd1);
    chk("Ierr_cnt",   32'(err_count), 32'd1);
    in_valid = 1'b0; tick;
    chk("err_cnt2", 32'(err_count), 32'd2);

    // Back-pressure: the output must hold while the sink stalls
    out_ready = 1'b0;
    drive(32'h0000_0013, 32'h0000_0005, 2'b00); tick;
    hold_instr = out_instr;
    hold_addr  = out_addr;
    chk("bp_instr0", out_instr, 32'h0050_0013);
    drive(32'h0000_0013, 32'h0000_0006, 2'b00);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_instr", out_instr, hold_instr);
      chk("bp_hold_addr", 32'(out_addr), 32'(hold_addr));
    end
    out_ready = 1'b1; tick;
    chk("bp_next", out_instr, 32'h0060_0013);
    in_valid = 1'b0; tick;
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      clr        = ($urandom_range(0, 29) == 0);
      in_base    = $urandom;
      in_imm     = rand_imm();
      in_imm_sel = 2'($urandom_range(0, 3));
      tick;
    end
    clr = 1'b0;

    // err_count saturation
    out_ready = 1'b1;
    for (int n = 0; n < 270; n++) begin
      drive($urandom, $urandom | 32'h1, 2'b11);
      tick;
    end
    in_valid = 1'b0; tick; tick;
    chk("sat_count", 32'(err_count), 32'hFF);

    // clr together with an output handshake
    drive(32'h0000_0013, 32'h0000_0001, 2'b00); tick;
    chk("clr_pre_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0; clr = 1'b1; tick;
    clr = 1'b0;
    chk("clr_addr", 32'(out_addr), 32'd12);
    chk("clr_cnt",  32'(err_count), 32'd0);

    // Asynchronous reset in the middle of a stream
    for (int n = 0; n < 3; n++) begin
      drive($urandom, $urandom | 32'h1, 2'b11);
      tick;
    end
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_addr",  32'(out_addr), 32'd12);
    chk("ar_cnt",   32'(err_count), 32'd0);
    in_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    drive(32'h0000_0037, 32'hABCD_E000, 2'b11); tick;
    chk("ar_first_addr",  32'(out_addr), 32'd12);
    chk("ar_first_instr", out_instr, 32'hABCD_E037);
    in_valid = 1'b0; tick; tick;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
